// File: rtl/chebyshev_clenshaw_eval_if.sv
// Sample-in / result-out stream bundle for the Clenshaw evaluator.
// The DUT uses the slave side; the source/sink of samples uses the master side.
interface chebyshev_clenshaw_eval_if #(
  parameter int WORD_LENGTH = 16,
  parameter int ORDER       = 8
);
  localparam int AW = $clog2(ORDER + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic signed [WORD_LENGTH-1:0] data_in;
  logic        [AW-1:0]          order_sel;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [WORD_LENGTH-1:0] data_out;
  logic                          sat;

  modport slave (
    input  in_valid, data_in, order_sel, out_ready,
    output in_ready, out_valid, data_out, sat
  );

  modport master (
    output in_valid, data_in, order_sel, out_ready,
    input  in_ready, out_valid, data_out, sat
  );
endinterface

// File: rtl/chebyshev_clenshaw_eval.sv
// Chebyshev series f(x)=sum c_k*T_k(x) via Clenshaw, one MAC per cycle; result n+1 cycles after accept.
// One sample in flight: in_ready only in IDLE, result held until out_ready; coefficient writes dropped while busy.
module chebyshev_clenshaw_eval #(
  parameter  int WORD_LENGTH  = 16,
  parameter  int COEFF_LENGTH = 16,
  parameter  int FRAC_BITS    = 14,
  parameter  int ACC_LENGTH   = 24,
  parameter  int ORDER        = 8,
  localparam int AW           = $clog2(ORDER + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           coeff_we,
  input  logic        [AW-1:0]           coeff_addr,
  input  logic signed [COEFF_LENGTH-1:0] coeff_wdata,
  chebyshev_clenshaw_eval_if.slave       io,
  output logic                           busy
);
  localparam int PW = WORD_LENGTH + ACC_LENGTH + 1;
  localparam int SW = PW + 2;

  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_LENGTH+1){1'b0}}, {(ACC_LENGTH-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_LENGTH+1){1'b1}}, {(ACC_LENGTH-1){1'b0}}};
  localparam logic signed [SW-1:0] WRD_MAX = {{(SW-WORD_LENGTH+1){1'b0}}, {(WORD_LENGTH-1){1'b1}}};
  localparam logic signed [SW-1:0] WRD_MIN = {{(SW-WORD_LENGTH+1){1'b1}}, {(WORD_LENGTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_t;

  state_t state, state_nxt;

  logic signed [COEFF_LENGTH-1:0] coeff [ORDER+1];
  logic signed [WORD_LENGTH-1:0]  x_q;
  logic        [AW-1:0]           k_q;
  logic signed [ACC_LENGTH-1:0]   b1_q, b2_q;
  logic                           sat_flag;
  logic signed [WORD_LENGTH-1:0]  y_q;
  logic                           sat_q;

  logic                           accept;
  logic        [AW-1:0]           n_sel;
  logic signed [PW-1:0]           x_ext, b1_ext, prod, term, shifted;
  logic signed [SW-1:0]           ck_w, sh_w, b2_w, sum;
  logic                           acc_hi, acc_lo, wrd_hi, wrd_lo;
  logic signed [ACC_LENGTH-1:0]   b_new;
  logic signed [WORD_LENGTH-1:0]  y_sat;
  logic signed [COEFF_LENGTH-1:0] ck;

  assign accept       = io.in_valid && (state == IDLE);
  assign n_sel        = (io.order_sel > AW'(ORDER)) ? AW'(ORDER) : io.order_sel;
  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.data_out  = y_q;
  assign io.sat       = sat_q;
  assign busy         = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (n_sel == '0) ? FINAL : ITER;
      ITER:    if (k_q == AW'(1)) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared datapath: ITER uses 2*x*b1 with c_k, FINAL uses x*b1 with c_0 (k has reached 0).
  always_comb begin
    ck      = coeff[k_q];
    x_ext   = {{(PW-WORD_LENGTH){x_q[WORD_LENGTH-1]}}, x_q};
    b1_ext  = {{(PW-ACC_LENGTH){b1_q[ACC_LENGTH-1]}}, b1_q};
    prod    = x_ext * b1_ext;
    term    = (state == ITER) ? (prod <<< 1) : prod;
    shifted = term >>> FRAC_BITS;
    ck_w    = {{(SW-COEFF_LENGTH){ck[COEFF_LENGTH-1]}}, ck};
    sh_w    = {{(SW-PW){shifted[PW-1]}}, shifted};
    b2_w    = {{(SW-ACC_LENGTH){b2_q[ACC_LENGTH-1]}}, b2_q};
    sum     = ck_w + sh_w - b2_w;
    acc_hi  = (sum > ACC_MAX);
    acc_lo  = (sum < ACC_MIN);
    wrd_hi  = (sum > WRD_MAX);
    wrd_lo  = (sum < WRD_MIN);
    b_new   = acc_hi ? {1'b0, {(ACC_LENGTH-1){1'b1}}} :
              acc_lo ? {1'b1, {(ACC_LENGTH-1){1'b0}}} : sum[ACC_LENGTH-1:0];
    y_sat   = wrd_hi ? {1'b0, {(WORD_LENGTH-1){1'b1}}} :
              wrd_lo ? {1'b1, {(WORD_LENGTH-1){1'b0}}} : sum[WORD_LENGTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q      <= '0;
      k_q      <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      sat_flag <= 1'b0;
      y_q      <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x_q      <= io.data_in;
          k_q      <= n_sel;
          b1_q     <= '0;
          b2_q     <= '0;
          sat_flag <= 1'b0;
        end
        ITER: begin
          b2_q <= b1_q;
          b1_q <= b_new;
          k_q  <= k_q - AW'(1);
          if (acc_hi || acc_lo) sat_flag <= 1'b1;
        end
        FINAL: begin
          y_q   <= y_sat;
          sat_q <= sat_flag | wrd_hi | wrd_lo;
        end
        default: ;
      endcase
    end
  end

  // Coefficients are frozen for the whole evaluation and held result.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= ORDER; i++) coeff[i] <= '0;
    end else if (coeff_we && !busy && (coeff_addr <= AW'(ORDER))) begin
      coeff[coeff_addr] <= coeff_wdata;
    end
  end
endmodule
